// File: rtl/dcache_axi_responder.sv
// ============================================================================
// Module  : dcache_axi_responder
// Brief   : Single-outstanding memory responder for the data-cache bus; optional
//           stall injection via RESP_BACKPRESSURE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_axi_responder #(
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int RD_LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_req,
  input  logic [31:0] r_addr,
  input  logic [2:0]  r_size,
  input  logic [7:0]  r_length,
  output logic        r_rdy,
  output logic        ret_valid,
  output logic        ret_last,
  output logic [31:0] r_data,
  input  logic        r_data_ready,
  input  logic        w_req,
  input  logic [31:0] w_addr,
  input  logic [2:0]  w_size,
  input  logic [7:0]  w_length,
  output logic        w_rdy,
  input  logic        w_data_req,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  input  logic        w_last,
  output logic        w_data_ready,
  output logic        b_valid,
  input  logic        b_ready,
  output logic        proto_err
);

  localparam int         c_DEPTH    = 1 << MEM_WORDS_LOG2;
  localparam logic [3:0] c_LAT_LAST = 4'((RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    R_WAIT  = 3'd1,
    R_BURST = 3'd2,
    W_DATA  = 3'd3,
    W_RESP  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]               r_mem [0:c_DEPTH-1];
  logic [MEM_WORDS_LOG2-1:0] r_idx;
  logic [7:0]                r_len;
  logic [7:0]                r_beat;
  logic [3:0]                r_lat;
  logic [31:0]               r_rd_word;
  logic                      r_err;

  logic [MEM_WORDS_LOG2-1:0] w_raddr_idx;
  logic [MEM_WORDS_LOG2-1:0] w_waddr_idx;
  logic [MEM_WORDS_LOG2-1:0] w_idx_nxt;
  logic                      w_last_beat;
  logic                      w_rd_hs;
  logic                      w_wr_hs;
  logic                      w_beat_shown;
  logic                      w_wr_open;
  logic                      w_unused_ok;

  assign w_raddr_idx = r_addr[MEM_WORDS_LOG2+1:2];
  assign w_waddr_idx = w_addr[MEM_WORDS_LOG2+1:2];
  assign w_idx_nxt   = r_idx + 1'b1;
  assign w_last_beat = (r_beat == r_len);
  assign w_rd_hs     = ret_valid & r_data_ready;
  assign w_wr_hs     = w_data_req & w_data_ready;
  assign w_unused_ok = ^{r_size, w_size, r_addr[1:0], r_addr[31:MEM_WORDS_LOG2+2],
                         w_addr[1:0], w_addr[31:MEM_WORDS_LOG2+2]};

`ifdef RESP_BACKPRESSURE_EN
  logic [15:0] r_lfsr;
  logic        r_shown;

  // A presented beat stays up until taken; a fresh beat waits for LFSR[0].
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr  <= 16'hACE1;
      r_shown <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      if (r_state != R_BURST || w_rd_hs)
        r_shown <= 1'b0;
      else if (r_lfsr[0])
        r_shown <= 1'b1;
    end
  end

  assign w_beat_shown = r_shown;
  assign w_wr_open    = r_lfsr[1];
`else
  assign w_beat_shown = 1'b1;
  assign w_wr_open    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Every handshake output is forced low while rst is high.
  always_comb begin
    w_state_nxt  = r_state;
    r_rdy        = 1'b0;
    w_rdy        = 1'b0;
    ret_valid    = 1'b0;
    w_data_ready = 1'b0;
    b_valid      = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          w_rdy = 1'b1;
          r_rdy = ~w_req;
          if (w_req)      w_state_nxt = W_DATA;
          else if (r_req) w_state_nxt = (RD_LATENCY == 1) ? R_BURST : R_WAIT;
        end
        R_WAIT: begin
          if (r_lat == c_LAT_LAST) w_state_nxt = R_BURST;
        end
        R_BURST: begin
          ret_valid = w_beat_shown;
          if (w_beat_shown && r_data_ready && w_last_beat) w_state_nxt = IDLE;
        end
        W_DATA: begin
          w_data_ready = w_wr_open;
          if (w_data_req && w_wr_open && w_last_beat) w_state_nxt = W_RESP;
        end
        W_RESP: begin
          b_valid = 1'b1;
          if (b_ready) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign ret_last  = ret_valid & w_last_beat;
  assign r_data    = rst ? 32'h0 : r_rd_word;
  assign proto_err = r_err & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_len     <= 8'h0;
      r_beat    <= 8'h0;
      r_lat     <= 4'h0;
      r_rd_word <= 32'h0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req || r_req) begin
            r_idx  <= w_req ? w_waddr_idx : w_raddr_idx;
            r_len  <= w_req ? w_length : r_length;
            r_beat <= 8'h0;
            r_lat  <= 4'h0;
            if (!w_req && RD_LATENCY == 1) r_rd_word <= r_mem[w_raddr_idx];
          end
        end
        R_WAIT: begin
          r_lat <= r_lat + 1'b1;
          if (r_lat == c_LAT_LAST) r_rd_word <= r_mem[r_idx];
        end
        R_BURST: begin
          if (w_rd_hs && !w_last_beat) begin
            r_idx     <= w_idx_nxt;
            r_beat    <= r_beat + 1'b1;
            r_rd_word <= r_mem[w_idx_nxt];
          end
        end
        W_DATA: begin
          if (w_wr_hs) begin
            if (w_last != w_last_beat) r_err <= 1'b1;
            if (!w_last_beat) begin
              r_idx  <= w_idx_nxt;
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) r_mem[r_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

endmodule

`default_nettype wire
